// File: rtl/sloth_pipe_pkg.sv
// Shared types and helpers for the Sloth pipeline hazard logic: the scoreboard
// entry layout, the operand-select encoding and the per-entry ready stage.
package sloth_pipe_pkg;

    // Tags are stored zero-extended to this width so one struct serves any REG_DEPTH up to 8.
    localparam int unsigned TAG_MAX_W   = 8;
    localparam int unsigned SEL_REGFILE = 0;

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 is_load;
        logic [TAG_MAX_W-1:0] dst;
        logic [TAG_MAX_W-1:0] src1;
        logic [TAG_MAX_W-1:0] src2;
        logic                 has_src1;
        logic                 has_src2;
    } sb_entry_t;

    // First scoreboard index at which an entry's result can be consumed.
    function automatic int unsigned ready_stage(
        input logic        fwd_en,
        input logic        is_load,
        input int unsigned load_ready,
        input int unsigned depth
    );
        if (!fwd_en)      return depth;
        else if (is_load) return load_ready;
        else              return 1;
    endfunction

endpackage

// File: rtl/sb_match.sv
// Compares one source tag against every scoreboard entry; returns the match
// vector and the lowest matching index at or above FIRST (0 when none).
module sb_match
    import sloth_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned FIRST = 0
) (
    input  logic [DEPTH*TAG_MAX_W-1:0]   i_dsts,
    input  logic [DEPTH-1:0]             i_wr_valid,
    input  logic [TAG_MAX_W-1:0]         i_src,
    input  logic                         i_has_src,
    output logic [DEPTH-1:0]             o_match,
    output logic [$clog2(DEPTH)-1:0]     o_idx
);

    localparam int unsigned SEL_W = $clog2(DEPTH);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        o_match = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            o_match[k] = i_has_src && i_wr_valid[k] &&
                         (i_dsts[k*TAG_MAX_W +: TAG_MAX_W] == i_src);
        end
    end

    // Scanning downward lets the youngest (lowest-index) producer overwrite older ones.
    always_comb begin
        o_idx = SEL_W'(SEL_REGFILE);
        for (int k = int'(DEPTH) - 1; k >= int'(FIRST); k--) begin
            if (o_match[k]) o_idx = SEL_W'(k);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Sloth pipeline hazard scoreboard: tracks in-flight instructions EXE..WB and
// drives the ID stall, EXE forwarding selects and saturating perf counters.
module hazard_scoreboard
    import sloth_pipe_pkg::*;
#(
    parameter int unsigned REG_DEPTH  = 4,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable_forwarding,
    input  logic                     id_valid,
    input  logic [REG_DEPTH-1:0]     id_src1,
    input  logic [REG_DEPTH-1:0]     id_src2,
    input  logic                     id_has_src1,
    input  logic                     id_has_src2,
    input  logic [REG_DEPTH-1:0]     id_dst,
    input  logic                     id_wb_en,
    input  logic                     id_mem_read,
    input  logic                     flush,
    input  logic                     cnt_clear,
    output logic                     stall,
    output logic [$clog2(DEPTH)-1:0] sel_src1,
    output logic [$clog2(DEPTH)-1:0] sel_src2,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [CNT_W-1:0]         forward_events
);

    localparam int unsigned SEL_W = $clog2(DEPTH);

    sb_entry_t                  r_sb [DEPTH];
    logic [CNT_W-1:0]           r_stall_cycles;
    logic [CNT_W-1:0]           r_forward_events;

    sb_entry_t                  w_id_entry;
    logic [DEPTH-1:0]           w_wr_valid;
    logic [DEPTH*TAG_MAX_W-1:0] w_dsts;
    logic [DEPTH-1:0]           w_id1_match;
    logic [DEPTH-1:0]           w_id2_match;
    logic [DEPTH-1:0]           w_exe1_match_unused;
    logic [DEPTH-1:0]           w_exe2_match_unused;
    logic [SEL_W-1:0]           w_id1_idx_unused;
    logic [SEL_W-1:0]           w_id2_idx_unused;
    logic [SEL_W-1:0]           w_exe1_idx;
    logic [SEL_W-1:0]           w_exe2_idx;
    logic                       w_hazard;
    logic                       w_fwd_event;

    always_comb begin
        w_id_entry          = '0;
        w_id_entry.valid    = id_valid;
        w_id_entry.wb_en    = id_wb_en;
        w_id_entry.is_load  = id_mem_read;
        w_id_entry.dst      = TAG_MAX_W'(id_dst);
        w_id_entry.src1     = TAG_MAX_W'(id_src1);
        w_id_entry.src2     = TAG_MAX_W'(id_src2);
        w_id_entry.has_src1 = id_has_src1;
        w_id_entry.has_src2 = id_has_src2;
    end

    always_comb begin
        w_wr_valid = '0;
        w_dsts     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_wr_valid[k]                       = r_sb[k].valid && r_sb[k].wb_en;
            w_dsts[k*TAG_MAX_W +: TAG_MAX_W]    = r_sb[k].dst;
        end
    end

    sb_match #(.DEPTH(DEPTH), .FIRST(0)) u_id_src1 (
        .i_dsts(w_dsts), .i_wr_valid(w_wr_valid),
        .i_src(w_id_entry.src1), .i_has_src(id_has_src1),
        .o_match(w_id1_match), .o_idx(w_id1_idx_unused)
    );

    sb_match #(.DEPTH(DEPTH), .FIRST(0)) u_id_src2 (
        .i_dsts(w_dsts), .i_wr_valid(w_wr_valid),
        .i_src(w_id_entry.src2), .i_has_src(id_has_src2),
        .o_match(w_id2_match), .o_idx(w_id2_idx_unused)
    );

    // EXE's own entry is excluded: its result is not available to itself.
    sb_match #(.DEPTH(DEPTH), .FIRST(1)) u_exe_src1 (
        .i_dsts(w_dsts), .i_wr_valid(w_wr_valid),
        .i_src(r_sb[0].src1), .i_has_src(r_sb[0].valid && r_sb[0].has_src1),
        .o_match(w_exe1_match_unused), .o_idx(w_exe1_idx)
    );

    sb_match #(.DEPTH(DEPTH), .FIRST(1)) u_exe_src2 (
        .i_dsts(w_dsts), .i_wr_valid(w_wr_valid),
        .i_src(r_sb[0].src2), .i_has_src(r_sb[0].valid && r_sb[0].has_src2),
        .o_match(w_exe2_match_unused), .o_idx(w_exe2_idx)
    );

    // Entry k sits at position k+1 relative to the ID instruction once it reaches EXE.
    always_comb begin
        w_hazard = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((w_id1_match[k] || w_id2_match[k]) &&
                (k + 1 < ready_stage(enable_forwarding, r_sb[k].is_load, LOAD_READY, DEPTH)))
                w_hazard = 1'b1;
        end
    end

    assign stall       = id_valid && w_hazard && !flush;
    assign sel_src1    = enable_forwarding ? w_exe1_idx : SEL_W'(SEL_REGFILE);
    assign sel_src2    = enable_forwarding ? w_exe2_idx : SEL_W'(SEL_REGFILE);
    assign w_fwd_event = (sel_src1 != SEL_W'(SEL_REGFILE)) || (sel_src2 != SEL_W'(SEL_REGFILE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this small array is plain flops, so it is reset; stale valid bits would raise stall.
            for (int unsigned k = 0; k < DEPTH; k++) r_sb[k] <= '0;
        end else begin
            r_sb[0] <= (id_valid && !stall && !flush) ? w_id_entry : '0;
            for (int unsigned k = 1; k < DEPTH; k++) r_sb[k] <= r_sb[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles   <= '0;
            r_forward_events <= '0;
        end else if (cnt_clear) begin
            r_stall_cycles   <= '0;
            r_forward_events <= '0;
        end else begin
            if (stall && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_fwd_event && (r_forward_events != {CNT_W{1'b1}}))
                r_forward_events <= r_forward_events + 1'b1;
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign forward_events = r_forward_events;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: hand-computed stall/select/counter
// expectations, plus a second deeper instance used to saturate the stall counter.
module tb_hazard_scoreboard;

    localparam int SAT_CYCLES = 75000;

    logic       clk;
    logic       rst_n;
    logic       enable_forwarding;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_has_src1;
    logic       id_has_src2;
    logic [3:0] id_dst;
    logic       id_wb_en;
    logic       id_mem_read;
    logic       flush;
    logic       cnt_clear;
    logic       stall;
    logic [1:0] sel_src1;
    logic [1:0] sel_src2;
    logic [15:0] stall_cycles;
    logic [15:0] forward_events;

    logic       s_id_valid;
    logic [3:0] s_id_src1;
    logic       s_id_has_src1;
    logic [3:0] s_id_dst;
    logic       s_id_wb_en;
    logic       s_cnt_clear;
    logic       s_stall;
    logic [2:0] s_sel_src1;
    logic [2:0] s_sel_src2;
    logic [15:0] s_stall_cycles;
    logic [15:0] s_forward_events;

    int vec_cnt = 0;
    int err_cnt = 0;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst_n), .enable_forwarding(enable_forwarding),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_has_src1(id_has_src1), .id_has_src2(id_has_src2),
        .id_dst(id_dst), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .flush(flush), .cnt_clear(cnt_clear), .stall(stall),
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .stall_cycles(stall_cycles), .forward_events(forward_events)
    );

    // Deep, forwarding-off instance: stalls 7 of every 8 cycles to reach saturation quickly.
    hazard_scoreboard #(.DEPTH(8)) dut_sat (
        .clk(clk), .rst(rst_n), .enable_forwarding(1'b0),
        .id_valid(s_id_valid), .id_src1(s_id_src1), .id_src2(4'd0),
        .id_has_src1(s_id_has_src1), .id_has_src2(1'b0),
        .id_dst(s_id_dst), .id_wb_en(s_id_wb_en), .id_mem_read(1'b0),
        .flush(1'b0), .cnt_clear(s_cnt_clear), .stall(s_stall),
        .sel_src1(s_sel_src1), .sel_src2(s_sel_src2),
        .stall_cycles(s_stall_cycles), .forward_events(s_forward_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_dst = 4'd0; id_wb_en = 1'b0; id_mem_read = 1'b0;
        id_has_src1 = 1'b0; id_src1 = 4'd0; id_has_src2 = 1'b0; id_src2 = 4'd0;
    endtask

    task automatic issue(input logic [3:0] dst, input logic wb, input logic ld,
                         input logic hs1, input logic [3:0] s1,
                         input logic hs2, input logic [3:0] s2);
        id_valid = 1'b1; id_dst = dst; id_wb_en = wb; id_mem_read = ld;
        id_has_src1 = hs1; id_src1 = s1; id_has_src2 = hs2; id_src2 = s2;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    task automatic clear_counters();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable_forwarding = 1'b1; flush = 1'b0; cnt_clear = 1'b0;
        idle();
        s_id_valid = 1'b0; s_id_src1 = 4'd0; s_id_has_src1 = 1'b0;
        s_id_dst = 4'd0; s_id_wb_en = 1'b0; s_cnt_clear = 1'b0;
        #12 rst_n = 1'b1;
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_sel1", sel_src1, 2'd0);
        check("rst_sel2", sel_src2, 2'd0);
        check("rst_stall_cnt", stall_cycles, 16'd0);
        check("rst_fwd_cnt", forward_events, 16'd0);
        tick();

        // ALU->ALU with forwarding: ADD r1 ; SUB r2,r1
        issue(4'd1, 1, 0, 0, 4'd0, 0, 4'd0); #1;
        check("alu_alu_stall_p", stall, 1'b0);
        tick();
        issue(4'd2, 1, 0, 1, 4'd1, 0, 4'd0); #1;
        check("alu_alu_stall_c", stall, 1'b0);
        tick();
        idle(); #1;
        check("alu_alu_sel1", sel_src1, 2'd1);
        check("alu_alu_sel2", sel_src2, 2'd0);
        tick();
        check("alu_alu_fwd_cnt", forward_events, 16'd1);
        drain();
        clear_counters();
        check("clear_stall_cnt", stall_cycles, 16'd0);
        check("clear_fwd_cnt", forward_events, 16'd0);

        // Load-use with forwarding: LDR r3 ; ADD r4,r3
        issue(4'd3, 1, 1, 0, 4'd0, 0, 4'd0); #1;
        tick();
        issue(4'd4, 1, 0, 1, 4'd3, 0, 4'd0); #1;
        check("ld_use_stall1", stall, 1'b1);
        tick();
        check("ld_use_stall_cnt_a", stall_cycles, 16'd1);
        check("ld_use_stall2", stall, 1'b0);
        tick();
        idle(); #1;
        check("ld_use_sel1", sel_src1, 2'd2);
        tick();
        check("ld_use_stall_cnt_b", stall_cycles, 16'd1);
        check("ld_use_fwd_cnt", forward_events, 16'd1);
        drain();

        // Forwarding off: ADD r1 ; SUB r2,r1 waits for write-through
        enable_forwarding = 1'b0;
        clear_counters();
        issue(4'd1, 1, 0, 0, 4'd0, 0, 4'd0); #1;
        tick();
        issue(4'd2, 1, 0, 1, 4'd1, 0, 4'd0); #1;
        check("nofwd_stall1", stall, 1'b1);
        tick();
        check("nofwd_stall2", stall, 1'b1);
        tick();
        check("nofwd_stall3", stall, 1'b0);
        tick();
        idle(); #1;
        check("nofwd_sel1", sel_src1, 2'd0);
        check("nofwd_stall_cnt", stall_cycles, 16'd2);
        drain();

        // Producer without wb_en, and consumer not reading its tag: no hazard
        issue(4'd1, 0, 0, 0, 4'd0, 0, 4'd0); #1;
        tick();
        issue(4'd2, 1, 0, 1, 4'd1, 0, 4'd0); #1;
        check("no_wb_no_stall", stall, 1'b0);
        tick();
        drain();
        issue(4'd1, 1, 0, 0, 4'd0, 0, 4'd0); #1;
        tick();
        issue(4'd2, 1, 0, 0, 4'd1, 0, 4'd0); #1;
        check("no_src_no_stall", stall, 1'b0);
        tick();
        drain();

        // Multiple producers: MOV r5 ; MOV r5 ; ADD r6,r5,r2
        enable_forwarding = 1'b1;
        issue(4'd5, 1, 0, 0, 4'd0, 0, 4'd0); #1;
        tick();
        issue(4'd5, 1, 0, 0, 4'd0, 0, 4'd0); #1;
        tick();
        issue(4'd6, 1, 0, 1, 4'd5, 1, 4'd2); #1;
        check("multi_stall", stall, 1'b0);
        tick();
        idle(); #1;
        check("multi_sel1_young", sel_src1, 2'd1);
        check("multi_sel2", sel_src2, 2'd0);
        tick();
        drain();

        // Tag 15 load feeding src2
        issue(4'd15, 1, 1, 0, 4'd0, 0, 4'd0); #1;
        tick();
        issue(4'd7, 1, 0, 0, 4'd0, 1, 4'd15); #1;
        check("tag15_stall1", stall, 1'b1);
        tick();
        check("tag15_stall2", stall, 1'b0);
        tick();
        idle(); #1;
        check("tag15_sel2", sel_src2, 2'd2);
        check("tag15_sel1", sel_src1, 2'd0);
        tick();
        drain();
        check("pre_flush_stall_cnt", stall_cycles, 16'd3);
        check("pre_flush_fwd_cnt", forward_events, 16'd2);

        // Flush coincident with load-use hazard
        issue(4'd3, 1, 1, 0, 4'd0, 0, 4'd0); #1;
        tick();
        issue(4'd4, 1, 0, 1, 4'd3, 0, 4'd0);
        flush = 1'b1; #1;
        check("flush_stall", stall, 1'b0);
        tick();
        flush = 1'b0;
        idle(); #1;
        check("flush_bubble_sel1", sel_src1, 2'd0);
        check("flush_stall_cnt", stall_cycles, 16'd3);
        drain();

        // Reset while a stall is being held
        enable_forwarding = 1'b0;
        issue(4'd1, 1, 0, 0, 4'd0, 0, 4'd0); #1;
        tick();
        issue(4'd2, 1, 0, 1, 4'd1, 0, 4'd0); #1;
        check("pre_rst_stall1", stall, 1'b1);
        tick();
        check("pre_rst_stall_cnt", stall_cycles, 16'd4);
        check("pre_rst_stall2", stall, 1'b1);
        rst_n = 1'b0; #1;
        check("rst_mid_stall", stall, 1'b0);
        check("rst_mid_sel1", sel_src1, 2'd0);
        check("rst_mid_stall_cnt", stall_cycles, 16'd0);
        check("rst_mid_fwd_cnt", forward_events, 16'd0);
        idle();
        rst_n = 1'b1;
        tick();

        // cnt_clear beats an increment in the same cycle
        issue(4'd1, 1, 0, 0, 4'd0, 0, 4'd0); #1;
        tick();
        issue(4'd2, 1, 0, 1, 4'd1, 0, 4'd0); #1;
        tick();
        check("clr_pre_cnt", stall_cycles, 16'd1);
        check("clr_pre_stall", stall, 1'b1);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        check("clear_beats_inc", stall_cycles, 16'd0);
        drain();

        // Saturation: main instance forwards every cycle, deep instance stalls 7/8 cycles
        enable_forwarding = 1'b1;
        for (int i = 0; i < SAT_CYCLES; i++) begin
            issue(4'd1, 1, 0, 1, 4'd1, 0, 4'd0);
            s_id_valid    = 1'b1;
            s_id_dst      = (i % 8 == 0) ? 4'd1 : 4'd2;
            s_id_wb_en    = 1'b1;
            s_id_has_src1 = (i % 8 != 0);
            s_id_src1     = 4'd1;
            if (i == 1) begin
                #1;
                check("sat_deep_stall", s_stall, 1'b1);
                check("sat_main_nostall", stall, 1'b0);
            end
            tick();
        end
        check("sat_fwd_cnt", forward_events, 16'hFFFF);
        check("sat_stall_cnt", s_stall_cycles, 16'hFFFF);
        check("sat_deep_fwd_zero", s_forward_events, 16'd0);
        cnt_clear   = 1'b1;
        s_cnt_clear = 1'b1;
        tick();
        cnt_clear   = 1'b0;
        s_cnt_clear = 1'b0;
        check("sat_clear_fwd", forward_events, 16'd0);
        check("sat_clear_stall", s_stall_cycles, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and forwarding-control block for the Sloth in-order pipeline. It tracks the destination, source and kind of every instruction in flight from EXE to WB in its own shift-register scoreboard. From that state it generates the ID-stage stall, the EXE-stage operand-forwarding selects, and saturating performance counters. Pipeline depth, register-file size and load latency are all configurable, and forwarding can be switched on or off at run time.

## Interface
- `REG_DEPTH`, 4: register tag width (16 architectural registers).
- `DEPTH`, 3: tracked stages after ID; entry 0 = EXE, entry `DEPTH-1` = WB.
- `LOAD_READY`, 2: first entry index from which load data can be forwarded.
- `CNT_W`, 16: performance counter width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `enable_forwarding` in 1: 1 = forward, 0 = stall until register-file write-through.
- `id_valid` in 1: ID holds a real instruction.
- `id_src1`, `id_src2` in `REG_DEPTH`: ID source tags.
- `id_has_src1`, `id_has_src2` in 1: source is actually read.
- `id_dst` in `REG_DEPTH`: ID destination tag.
- `id_wb_en` in 1: ID instruction writes the register file.
- `id_mem_read` in 1: ID instruction is a load.
- `flush` in 1: branch taken in EXE.
- `cnt_clear` in 1: synchronous clear of both counters.
- `stall` out 1: freeze PC, IF/ID and ID; insert a bubble into EXE.
- `sel_src1`, `sel_src2` out `$clog2(DEPTH)`: EXE operand source. 0 = ID/EXE register value; k = result of entry k.
- `stall_cycles` out `CNT_W`: saturating count of cycles with `stall`=1.
- `forward_events` out `CNT_W`: saturating count of cycles with a nonzero select on either operand.

## Operation
- Each entry holds: valid, wb_en, is_load, dst, src1, src2, has_src1, has_src2.
- Ready stage of an entry:
  - forwarding on: 1 for non-loads, `LOAD_READY` for loads.
  - forwarding off: `DEPTH` for all entries.
- An ID source matches entry k when all of these hold: entry valid, wb_en=1, has_src=1, and dst equals the source tag.
- `hazard` = some ID source matches some entry k with k+1 < ready stage. Entry k is the producer position once the ID instruction reaches EXE.
- `stall` = `id_valid` & `hazard` & !`flush`.
- Forwarding selects (forwarding on):
  - For each EXE source (entry 0 fields), pick the lowest k in 1..`DEPTH-1` that matches; the youngest producer wins.
  - Select is 0 when there is no match.
- Forwarding selects (forwarding off): both selects are 0.
- A register-file tag 15 (PC) match is treated like any other tag; no special case.

## Timing
- Every rising edge shifts the scoreboard: entry[k] <= entry[k-1] for k ≥ 1.
- Entry 0 loads the ID instruction only when `id_valid` & !`stall` & !`flush`; otherwise it loads a bubble (valid=0).
- `flush` and a hazard in the same cycle: the flush wins; `stall`=0 and entry 0 becomes a bubble.
- Latency:
  - `stall` and the selects are combinational from current inputs and scoreboard state.
  - Counters update one cycle after the event.
- Counters:
  - Increment by 1 per qualifying cycle and hold at all-ones.
  - `cnt_clear` wins over an increment in the same cycle.
- Reset, asynchronous and at any time: all entries invalid, both counters 0, hence `stall`=0 and selects 0. This holds even mid-stall.

## Structure
- Shared package `sloth_pipe_pkg` holds:
  - the `sb_entry_t` struct;
  - the select encoding constant `SEL_REGFILE`=0;
  - a ready-stage function shared with the EXE operand mux.
- One natural sub-module, `sb_match`: combinational tag compare of one source against all entries. It returns a match vector and the index of the lowest match, and is instantiated four times (ID src1/src2, EXE src1/src2).
- Scoreboard storage, stall logic and counters live in the top module.

## Test plan
- ALU→ALU, forwarding on: `ADD r1` followed directly by `SUB r2,r1` → `stall`=0; `sel_src1`=1 while the SUB is in EXE; `forward_events` = 1.
- Load-use, forwarding on: `LDR r3` followed directly by `ADD r4,r3` → `stall`=1 for exactly 1 cycle, then `sel_src1`=2; `stall_cycles` = 1.
- Forwarding off: the same ALU→ALU pair → `stall`=1 for 2 cycles; selects stay 0; the consumer enters EXE 3 cycles after the producer.
- Multiple producers: `MOV r5`, `MOV r5`, `ADD r6,r5` → `sel_src1`=1, selecting the younger MOV and not entry 2.
- `flush` asserted in the same cycle as a load-use hazard → `stall`=0; entry 0 is a bubble next cycle; `stall_cycles` unchanged.
- Hold the stall and assert `rst` low mid-stall → `stall`=0 immediately. Saturation: preload the counters to 16'hFFFF via a long stall → they hold at 16'hFFFF; `cnt_clear` → 0.
